// File: rtl/acq_store_ctrl.sv
// -----------------------------------------------------------------------------
// acq_store_ctrl
//   Acquisition controller that sits downstream of the disc reader. It gates
//   the reader RUN line. It takes the reader's byte stream (DATA + WRITE
//   strobe) and writes it unchanged into the acquisition SRAM at sequential
//   addresses. A run can wait for an index edge before capturing. It stops
//   after a programmable number of index edges, when memory is full, or on a
//   host abort. After RUN drops, a short flush window keeps accepting bytes.
//
// Ports
//   CLOCK, RESET_N            rising-edge clock, asynchronous active-low reset
//   START, ABORT              host 1-cycle command pulses (ABORT wins)
//   WAIT_INDEX, STOP_IDX      run configuration, sampled while running
//   INDEX_IN                  index level, already synchronous to CLOCK
//   RD_DATA, RD_WRITE         reader byte stream, one strobe per byte
//   RD_RUN                    reader enable, high only while acquiring
//   MEM_ADDR/MEM_WDATA/MEM_WE SRAM write port, one registered write per byte
//   BUSY, DONE, FULL, OVERRUN status flags for the host register file
//   BYTE_COUNT                bytes stored in the current/last run
// -----------------------------------------------------------------------------
module acq_store_ctrl #(
    parameter int ADDR_WIDTH   = 19,
    parameter int FLUSH_CYCLES = 8
) (
    input  logic                  CLOCK,
    input  logic                  RESET_N,
    input  logic                  START,
    input  logic                  ABORT,
    input  logic                  WAIT_INDEX,
    input  logic [7:0]            STOP_IDX,
    input  logic                  INDEX_IN,
    input  logic [7:0]            RD_DATA,
    input  logic                  RD_WRITE,
    output logic                  RD_RUN,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [7:0]            MEM_WDATA,
    output logic                  MEM_WE,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  FULL,
    output logic                  OVERRUN,
    output logic [ADDR_WIDTH:0]   BYTE_COUNT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_ACQUIRE,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0] LAST_ADDR  = {1'b0, {ADDR_WIDTH{1'b1}}};
    localparam logic [ADDR_WIDTH:0] CNT_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [7:0]          FLUSH_LAST = 8'(FLUSH_CYCLES - 1);

    state_t                  state_q, state_d;
    logic                    index_q;
    logic [7:0]              idx_cnt_q, idx_cnt_d;
    logic [7:0]              flush_cnt_q, flush_cnt_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic                    full_q, full_d;
    logic                    ovr_q, ovr_d;
    logic                    rd_run_q, rd_run_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]              mem_wdata_q, mem_wdata_d;

    logic                    idx_rise;
    logic                    storing;
    logic                    abort_hit;
    logic                    start_ok;
    logic                    store_now;
    logic                    full_set;
    logic                    stop_hit;
    logic [7:0]              idx_cnt_inc;

    always_comb begin
        idx_rise    = INDEX_IN & ~index_q;
        storing     = (state_q == S_ACQUIRE) || (state_q == S_FLUSH);
        abort_hit   = ABORT && (state_q != S_IDLE);
        start_ok    = START && !ABORT && ((state_q == S_IDLE) || (state_q == S_DONE));
        store_now   = storing && RD_WRITE && !full_q && !abort_hit;
        // BYTE_COUNT doubles as the write pointer; the top bit only becomes
        // set once the final location has been written, so it never wraps.
        full_set    = store_now && (count_q == LAST_ADDR);
        idx_cnt_inc = (idx_cnt_q == 8'hFF) ? idx_cnt_q : idx_cnt_q + 8'd1;
        stop_hit    = 1'b0;

        state_d     = state_q;
        idx_cnt_d   = idx_cnt_q;
        flush_cnt_d = flush_cnt_q;
        count_d     = count_q;
        full_d      = full_q;
        ovr_d       = ovr_q;
        mem_we_d    = store_now;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        if (store_now) begin
            mem_addr_d  = count_q[ADDR_WIDTH-1:0];
            mem_wdata_d = RD_DATA;
            count_d     = count_q + CNT_ONE;
        end
        if (full_set) begin
            full_d = 1'b1;
        end
        if (storing && RD_WRITE && full_q && !abort_hit) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok) begin
                    state_d   = WAIT_INDEX ? S_ARM : S_ACQUIRE;
                    count_d   = '0;
                    idx_cnt_d = 8'd0;
                    full_d    = 1'b0;
                    ovr_d     = 1'b0;
                end
            end
            S_ARM: begin
                // The arming edge only opens the window; it is not counted.
                if (idx_rise) begin
                    state_d = S_ACQUIRE;
                end
            end
            S_ACQUIRE: begin
                if (idx_rise) begin
                    idx_cnt_d = idx_cnt_inc;
                    if ((STOP_IDX != 8'd0) && (idx_cnt_inc == STOP_IDX)) begin
                        stop_hit = 1'b1;
                    end
                end
                // Index stop and memory full share one FLUSH entry.
                if (stop_hit || full_set || full_q) begin
                    state_d     = S_FLUSH;
                    flush_cnt_d = 8'd0;
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = S_DONE;
                end else begin
                    flush_cnt_d = flush_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort_hit) begin
            state_d = S_IDLE;
        end

        // Status outputs are registered from the next state so they line up
        // exactly with the state register.
        rd_run_d = (state_d == S_ACQUIRE);
        busy_d   = (state_d == S_ARM) || (state_d == S_ACQUIRE) || (state_d == S_FLUSH);
        done_d   = (state_d == S_DONE);
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            index_q     <= 1'b0;
            idx_cnt_q   <= 8'd0;
            flush_cnt_q <= 8'd0;
            count_q     <= '0;
            full_q      <= 1'b0;
            ovr_q       <= 1'b0;
            rd_run_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            index_q     <= INDEX_IN;
            idx_cnt_q   <= idx_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            count_q     <= count_d;
            full_q      <= full_d;
            ovr_q       <= ovr_d;
            rd_run_q    <= rd_run_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign RD_RUN     = rd_run_q;
    assign MEM_ADDR   = mem_addr_q;
    assign MEM_WDATA  = mem_wdata_q;
    assign MEM_WE     = mem_we_q;
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign FULL       = full_q;
    assign OVERRUN    = ovr_q;
    assign BYTE_COUNT = count_q;

endmodule
